// File: rtl/alu_rr_arbiter.sv
// alu_rr_arbiter: two requesters share one combinational 8-bit ALU through a
// round-robin grant. Each request is captured into operand registers, held for
// one cycle (or MUL_CYCLES for multiply), and returned as a valid/ready response.

// Combinational ALU: add/sub with carry-borrow, full 16-bit multiply, all-ones
module alu8 (
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    input  logic        c,
    input  logic [1:0]  sel,
    output logic [15:0] out,
    output logic        flag
);
    logic [8:0] add_res;
    logic [8:0] sub_res;

    // Select one operation; bit 8 of the 9-bit add/sub result is the carry or borrow
    always_comb begin
        add_res = {1'b0, a} + {1'b0, b} + {8'd0, c};
        sub_res = {1'b0, a} - {1'b0, b} - {8'd0, c};
        out     = 16'h0000;
        flag    = 1'b0;
        case (sel)
            2'b00: begin
                out  = {8'h00, add_res[7:0]};
                flag = add_res[8];
            end
            2'b01: begin
                out  = {8'h00, sub_res[7:0]};
                flag = sub_res[8];
            end
            2'b10: out = {8'h00, a} * {8'h00, b};
            default: out = 16'hFFFF;
        endcase
    end
endmodule

module alu_rr_arbiter #(
    parameter int MUL_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [7:0]  req0_a,
    input  logic [7:0]  req0_b,
    input  logic        req0_c,
    input  logic [1:0]  req0_sel,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [7:0]  req1_a,
    input  logic [7:0]  req1_b,
    input  logic        req1_c,
    input  logic [1:0]  req1_sel,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_out,
    output logic        rsp_flag,
    output logic        rsp_id,
    output logic        busy
);
    // Multiply time is clamped to at least one cycle
    localparam int MUL_EFF = (MUL_CYCLES < 1) ? 1 : MUL_CYCLES;
    localparam int CW = (MUL_EFF > 1) ? $clog2(MUL_EFF) : 1;
    localparam logic [CW-1:0] MUL_LOAD = CW'(MUL_EFF - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t        state;
    state_t        state_next;
    logic          prio;
    logic [7:0]    op_a;
    logic [7:0]    op_b;
    logic          op_c;
    logic [1:0]    op_sel;
    logic          op_id;
    logic [CW-1:0] exec_cnt;
    logic          grant0;
    logic          grant1;
    logic          exec_done;
    logic          handshake;
    logic [7:0]    in_a;
    logic [7:0]    in_b;
    logic          in_c;
    logic [1:0]    in_sel;
    logic [15:0]   alu_out;
    logic          alu_flag;

    // The ALU only ever sees the latched operands, so requesters may move on after accept
    alu8 u_alu (
        .a    (op_a),
        .b    (op_b),
        .c    (op_c),
        .sel  (op_sel),
        .out  (alu_out),
        .flag (alu_flag)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state, round-robin grant and response valid
    always_comb begin
        state_next = state;
        grant0     = 1'b0;
        grant1     = 1'b0;
        rsp_valid  = 1'b0;
        case (state)
            IDLE: begin
                grant0 = req0_valid && (!req1_valid || !prio);
                grant1 = req1_valid && (!req0_valid || prio);
                if (grant0 || grant1) begin
                    state_next = EXEC;
                end
            end
            EXEC: begin
                if (exec_cnt == '0) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Operand mux feeding the capture registers from whichever port wins
    always_comb begin
        in_a   = grant1 ? req1_a   : req0_a;
        in_b   = grant1 ? req1_b   : req0_b;
        in_c   = grant1 ? req1_c   : req0_c;
        in_sel = grant1 ? req1_sel : req0_sel;
    end

    // Ready is masked while reset is held so no port sees an acceptance then
    assign req0_ready = grant0 && rst_n;
    assign req1_ready = grant1 && rst_n;
    assign busy       = (state != IDLE);
    assign exec_done  = (state == EXEC) && (exec_cnt == '0);
    assign handshake  = (state == RESP) && rsp_ready;

    // Operand capture, EXEC countdown, response registers and round-robin pointer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_a     <= 8'h00;
            op_b     <= 8'h00;
            op_c     <= 1'b0;
            op_sel   <= 2'b00;
            op_id    <= 1'b0;
            exec_cnt <= '0;
            rsp_out  <= 16'h0000;
            rsp_flag <= 1'b0;
            rsp_id   <= 1'b0;
            prio     <= 1'b0;
        end else begin
            if (state == IDLE && (grant0 || grant1)) begin
                op_a     <= in_a;
                op_b     <= in_b;
                op_c     <= in_c;
                op_sel   <= in_sel;
                op_id    <= grant1;
                exec_cnt <= (in_sel == 2'b10) ? MUL_LOAD : '0;
            end else if (state == EXEC && exec_cnt != '0) begin
                exec_cnt <= exec_cnt - CW'(1);
            end
            if (exec_done) begin
                rsp_out  <= alu_out;
                rsp_flag <= alu_flag;
                rsp_id   <= op_id;
            end
            if (handshake) begin
                prio <= ~op_id;
            end
        end
    end
endmodule
